// File: rtl/inst_queue_if.sv
// Fetch-to-decoder handshake bundle for the instruction queue.
// The master modport is the fetch/decoder side; the slave modport is the queue.
interface inst_queue_if #(
   parameter int INST_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 17,
   parameter int QUEUE_SIZE_LOG = 4
);
   logic                             inst_queue_entry_valid;
   logic [ADDR_WIDTH+INST_WIDTH-1:0] inst_queue_entry;
   logic                             inst_queue_ready;
   logic                             dec_ready;
   logic                             dec_valid;
   logic [ADDR_WIDTH-1:0]            dec_pc;
   logic [INST_WIDTH-1:0]            dec_inst;
   logic [QUEUE_SIZE_LOG:0]          queue_count;

   modport master (
      output inst_queue_entry_valid,
      output inst_queue_entry,
      output dec_ready,
      input  inst_queue_ready,
      input  dec_valid,
      input  dec_pc,
      input  dec_inst,
      input  queue_count
   );

   modport slave (
      input  inst_queue_entry_valid,
      input  inst_queue_entry,
      input  dec_ready,
      output inst_queue_ready,
      output dec_valid,
      output dec_pc,
      output dec_inst,
      output queue_count
   );
endinterface

// File: rtl/inst_queue.sv
// Circular FIFO of {pc, instruction} entries between fetch and decode.
// Flush (branch redirect) and reset empty the queue; rdy=0 freezes all state.
module inst_queue #(
   parameter int INST_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 17,
   parameter int QUEUE_SIZE_LOG = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         rdy,
   input  logic         flush,
   inst_queue_if.slave  q
);
   localparam int ENTRY_WIDTH = ADDR_WIDTH + INST_WIDTH;
   localparam int DEPTH       = 2 ** QUEUE_SIZE_LOG;
   localparam logic [QUEUE_SIZE_LOG:0]   FULL_COUNT = DEPTH[QUEUE_SIZE_LOG:0];
   localparam logic [QUEUE_SIZE_LOG:0]   CNT_ONE    = 1;
   localparam logic [QUEUE_SIZE_LOG-1:0] PTR_ONE    = 1;

   logic [ENTRY_WIDTH-1:0]    storage [DEPTH];
   logic [QUEUE_SIZE_LOG-1:0] head;
   logic [QUEUE_SIZE_LOG-1:0] tail;
   logic [QUEUE_SIZE_LOG:0]   count;

   logic                      empty;
   logic                      full;
   logic                      active;
   logic                      push;
   logic                      pop;
   logic [ENTRY_WIDTH-1:0]    head_entry;

   // Handshakes are masked during reset, stall and flush so no transfer can slip through.
   always_comb begin
      empty  = (count == '0);
      full   = (count == FULL_COUNT);
      active = rst & rdy & ~flush;
      q.inst_queue_ready = active & ~full;
      q.dec_valid        = active & ~empty;
      push = q.inst_queue_entry_valid & q.inst_queue_ready;
      pop  = q.dec_valid & q.dec_ready;
   end

   always_comb begin
      head_entry    = storage[head];
      q.dec_pc      = head_entry[ENTRY_WIDTH-1:INST_WIDTH];
      q.dec_inst    = head_entry[INST_WIDTH-1:0];
      q.queue_count = count;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (rdy) begin
         if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            if (push) tail <= tail + PTR_ONE;
            if (pop)  head <= head + PTR_ONE;
            case ({push, pop})
               2'b10:   count <= count + CNT_ONE;
               2'b01:   count <= count - CNT_ONE;
               default: count <= count;
            endcase
         end
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push) storage[tail] <= q.inst_queue_entry;
   end
endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Circular FIFO between the instruction fetch stage and the decoder.
- Buffers {pc, instruction} entries and accepts them through a valid/ready handshake.
- Presents the oldest entry to the decoder through a second valid/ready handshake.
- A flush input discards all buffered entries on a branch redirect.

Parameters:
- INST_WIDTH, 32, instruction width in bits.
- ADDR_WIDTH, 17, program counter width in bits.
- QUEUE_SIZE_LOG, 4, log2 of queue depth (depth = 16 entries).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-low: rst==0 at a posedge resets the block.
- rdy  input  1  global enable; when 0, all state holds and no transfers occur.
- flush  input  1  discard all entries (branch redirect).
- inst_queue_entry_valid  input  1  fetch stage offers an entry.
- inst_queue_entry  input  ADDR_WIDTH+INST_WIDTH  offered entry; high bits = pc, low bits = instruction.
- inst_queue_ready  output  1  queue accepts an entry this cycle.
- dec_ready  input  1  decoder consumes the head entry this cycle.
- dec_valid  output  1  head entry is valid.
- dec_pc  output  ADDR_WIDTH  pc of the head entry.
- dec_inst  output  INST_WIDTH  instruction of the head entry.
- queue_count  output  QUEUE_SIZE_LOG+1  number of occupied entries.

Behaviour:
- State:
  - head and tail pointers, QUEUE_SIZE_LOG bits each; wrap naturally modulo depth.
  - count, QUEUE_SIZE_LOG+1 bits, range 0..2^QUEUE_SIZE_LOG.
  - storage: register array of 2^QUEUE_SIZE_LOG entries, each ADDR_WIDTH+INST_WIDTH bits.
- Derived flags: empty = (count==0); full = (count==2^QUEUE_SIZE_LOG).
- Combinational outputs:
  - inst_queue_ready = rst & rdy & ~flush & ~full.
  - dec_valid = rst & rdy & ~flush & ~empty.
  - dec_pc and dec_inst are read combinationally from storage[head]; their values are don't-care when dec_valid==0.
  - queue_count = count.
- Transfers:
  - push = inst_queue_entry_valid & inst_queue_ready.
  - pop = dec_valid & dec_ready.
- Reset (rst==0 at posedge):
  - head=0, tail=0, count=0; storage contents are don't-care.
  - Outputs while reset is held: inst_queue_ready=0, dec_valid=0, queue_count=0 after the first reset edge.
  - Reset mid-operation drops all entries without any further pop.
- Priority at each posedge: reset > (rdy==0: hold everything) > flush > push/pop.
- Flush (rdy==1): head=0, tail=0, count=0. Any push or pop offered in the same cycle is ignored; ready and valid are already 0 that cycle.
- Push: storage[tail] <= inst_queue_entry; tail <= tail+1.
- Pop: head <= head+1.
- Count update: push only → +1; pop only → −1; push and pop together → unchanged.
- Latency:
  - An entry pushed at edge N is visible on dec_valid/dec_pc/dec_inst after edge N. There is no same-cycle bypass from input to output.
  - When empty, a push and a pop cannot both occur in one cycle.
- Full: inst_queue_ready=0 even if a pop occurs the same cycle; no push-through-when-full. Capacity recovers in the cycle after the pop.
- Wrap-around: tail and head roll over from 2^QUEUE_SIZE_LOG−1 to 0; entries keep FIFO order across the wrap.
- Fetch side holds inst_queue_entry_valid and data stable until accepted; the queue samples only on push.
- Decoder may assert dec_ready at any time; pop occurs only when dec_valid==1.
- rdy==0: no pointer, count or storage change; both handshake outputs are 0.

Test Plan:
- Reset then fill: hold rst=0 for 2 cycles, release. Push pc=0x0,4,8… with inst=0x00000013+k, dec_ready=0. → inst_queue_ready=1 until count=16; then 0 with queue_count=16; dec_pc=0x0, dec_inst=0x00000013.
- Drain order: from full, set dec_ready=1 for 16 cycles. → dec_pc sequence 0x0,0x4,…,0x3C in order; dec_valid=0 and queue_count=0 after the 16th pop; inst_queue_ready reasserts the cycle after the first pop.
- Concurrent push/pop with wrap: keep count at 3 while streaming 40 entries (push and pop every cycle). → queue_count stays 3; output pcs strictly sequential across the pointer wrap at 16 and 32.
- Full plus simultaneous pop: at count=16 assert entry_valid and dec_ready. → only the pop happens (count=15); the pending entry is accepted the next cycle (count stays 15 with push+pop, or 16 if dec_ready drops).
- Flush: with 5 entries queued, assert flush for one cycle together with entry_valid and dec_ready. → ready=0 and valid=0 that cycle; next cycle queue_count=0, dec_valid=0; a new push of pc=0x100 then appears as dec_pc=0x100.
- rdy stall and reset mid-operation: with 4 entries queued, drop rdy for 3 cycles while offering push and pop. → count stays 4, both handshake outputs 0. Then assert rst=0 for one edge. → queue_count=0, dec_valid=0.
